w_input_conditioner: RTL and testbench
======================================

Name: w_input_conditioner

Overview:
- Upstream stage of the two-consecutive-ones Mealy detector. Turns a raw, asynchronous, bouncy switch or button level into the clean, single-clock-domain `w` level that the detector samples on every clock.
- Data path: synchronizer chain, then a debounce FSM with a stability counter, then a registered `w` output.
- Goal: the detector's `z` output never fires on a bounce glitch.

Parameters:
- SYNC_STAGES, 2: number of flops in the synchronizer chain. Legal range 2..4.
- DEBOUNCE_CYCLES, 4: consecutive synchronized samples that must disagree with the current `w` before `w` toggles. Legal range 2..255.
- CNT_W, 8: stability counter width. Requires DEBOUNCE_CYCLES < 2**CNT_W.

Ports:
- clk, input, 1: single system clock. All state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset. Asserted (0) clears all state immediately. Deassertion is expected synchronous to clk.
- w_raw, input, 1: raw asynchronous switch level.
- w, output, 1: debounced, synchronized level. Feeds the detector's `w` input.
- busy, output, 1: high while a candidate transition is being qualified.
- w_rise, output, 1: one-cycle pulse when `w` goes 0→1. Tied 0 unless EDGE_OUT_EN.
- w_fall, output, 1: one-cycle pulse when `w` goes 1→0. Tied 0 unless EDGE_OUT_EN.

Behaviour:
- Reset (reset=0): synchronizer flops=0, state=S_LO, cnt=0, w=0, busy=0, w_rise=0, w_fall=0. Takes effect asynchronously, including mid-qualification; the pending count is discarded.
- Synchronizer: w_raw shifts through SYNC_STAGES flops. `s` denotes the last flop's output. The FSM uses only `s`.
- FSM states:
  - S_LO: w=0, idle.
  - S_LO_CHK: w=0, qualifying a rise.
  - S_HI: w=1, idle.
  - S_HI_CHK: w=1, qualifying a fall.
- Transitions, evaluated each rising edge:
  - S_LO: if s=1 → S_LO_CHK, cnt=1. Otherwise stay, cnt=0.
  - S_LO_CHK: if s=0 → S_LO, cnt=0 (bounce rejected). Else if cnt==DEBOUNCE_CYCLES-1 → S_HI, cnt=0. Else cnt=cnt+1.
  - S_HI: if s=0 → S_HI_CHK, cnt=1. Otherwise stay.
  - S_HI_CHK: if s=1 → S_HI, cnt=0. Else if cnt==DEBOUNCE_CYCLES-1 → S_LO, cnt=0. Else cnt=cnt+1.
  - Illegal/unused encodings → S_LO, cnt=0.
- Outputs:
  - w is a registered Moore output: 1 in S_HI and S_HI_CHK, 0 otherwise.
  - busy=1 in the two CHK states.
- Latency: w_raw stable from before edge 1 means w changes after edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults, w changes after edge 6.
- A pulse on w_raw shorter than DEBOUNCE_CYCLES clocks, measured at `s`, never changes w.
- Any single-sample disagreement during CHK restarts qualification from scratch. There is no partial credit.
- Counter arithmetic is unsigned CNT_W bits. It never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.

Optional Feature:
- Macro: W_INPUT_CONDITIONER_EDGE_OUT_EN.
- Defined:
  - w_rise is registered high for exactly one cycle, the same cycle w first reads 1.
  - w_fall is registered high for exactly one cycle, the same cycle w first reads 0.
  - Both are cleared by reset.
  - They are never high simultaneously.
- Undefined: w_rise and w_fall are driven constant 0, with no extra flops. The port list is unchanged.

Decomposition:
- Package w_cond_pkg holds:
  - state encoding constants S_LO=2'd0, S_LO_CHK=2'd1, S_HI=2'd2, S_HI_CHK=2'd3;
  - default parameter values;
  - a CNT_W sizing helper constant.
- Sub-module sync_chain: parameterised SYNC_STAGES-flop synchronizer with the same clk and active-low asynchronous reset. Reused by future switch inputs.

Test Plan:
- Reset: hold reset=0 for 3 clocks with w_raw=1 → w=0, busy=0, w_rise=0, w_fall=0 throughout. Release → w=1 after edge 6.
- Clean rise: w_raw 0→1 before edge 1, then held → w=0 through edge 5, w=1 after edge 6. With macro, w_rise=1 for that cycle only. busy=1 from edge 3 to edge 5.
- Bounce rejection: w_raw pattern high 3 clocks, low 1, high 2, low → w stays 0 throughout. busy returns to 0.
- Clean fall from w=1: w_raw held 0 → w=0 exactly 6 edges later. With macro, a single w_fall pulse.
- Reset mid-qualification: assert reset while in S_LO_CHK with cnt=2 → immediate w=0, busy=0. After release with w_raw=1, the full 6-edge latency applies again.
- Parameter sweep: DEBOUNCE_CYCLES=2, SYNC_STAGES=3 → clean rise visible after edge 5. A 1-clock glitch is rejected.

Source files
------------

// File: rtl/w_cond_pkg.sv
// Shared definitions for the w input conditioner: debounce FSM state
// encoding, default parameter values and a counter sizing helper.
package w_cond_pkg;

    typedef enum logic [1:0] {
        S_LO     = 2'd0,
        S_LO_CHK = 2'd1,
        S_HI     = 2'd2,
        S_HI_CHK = 2'd3
    } state_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF           = 8;

    // Number of bits needed to hold any count in 0..max_count.
    function automatic int cnt_bits(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    // Smallest counter that fits the default debounce length.
    localparam int CNT_W_MIN = cnt_bits(DEBOUNCE_CYCLES_DEF - 1);

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level.
// STAGES flops deep (2..4); async active-low reset clears the chain to 0.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the raw level through the synchronizer flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/w_input_conditioner.sv
// Debounces a raw switch level into the clean, synchronous `w` level.
// Path: sync_chain -> debounce FSM with stability counter -> registered w.
// Optional macro W_INPUT_CONDITIONER_EDGE_OUT_EN enables one-cycle
// w_rise / w_fall pulses; without it both are tied low with no flops.
module w_input_conditioner
    import w_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic w_raw,
    output logic w,
    output logic busy,
    output logic w_rise,
    output logic w_fall
);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s_s;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             w_r;
    logic             busy_r;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (w_raw),
        .q     (s_s)
    );

    // Debounce FSM; w and busy are registered alongside the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_LO;
            cnt_r   <= CNT_ZERO;
            w_r     <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                S_LO: begin
                    w_r <= 1'b0;
                    if (s_s) begin
                        state_r <= S_LO_CHK;
                        cnt_r   <= CNT_ONE;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= S_LO;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end
                end
                S_LO_CHK: begin
                    if (!s_s) begin
                        // Bounce: drop all accumulated credit.
                        state_r <= S_LO;
                        cnt_r   <= CNT_ZERO;
                        w_r     <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= S_HI;
                        cnt_r   <= CNT_ZERO;
                        w_r     <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= S_LO_CHK;
                        cnt_r   <= cnt_r + CNT_ONE;
                        w_r     <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                S_HI: begin
                    w_r <= 1'b1;
                    if (!s_s) begin
                        state_r <= S_HI_CHK;
                        cnt_r   <= CNT_ONE;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= S_HI;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end
                end
                S_HI_CHK: begin
                    if (s_s) begin
                        state_r <= S_HI;
                        cnt_r   <= CNT_ZERO;
                        w_r     <= 1'b1;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= S_LO;
                        cnt_r   <= CNT_ZERO;
                        w_r     <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= S_HI_CHK;
                        cnt_r   <= cnt_r + CNT_ONE;
                        w_r     <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_LO;
                    cnt_r   <= CNT_ZERO;
                    w_r     <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign w    = w_r;
    assign busy = busy_r;

`ifdef W_INPUT_CONDITIONER_EDGE_OUT_EN
    logic rise_s;
    logic fall_s;
    logic w_rise_r;
    logic w_fall_r;

    // Detect the edge that completes a qualification in either direction.
    always_comb begin
        rise_s = 1'b0;
        fall_s = 1'b0;
        if ((state_r == S_LO_CHK) && s_s && (cnt_r == CNT_LAST)) begin
            rise_s = 1'b1;
        end else if ((state_r == S_HI_CHK) && !s_s && (cnt_r == CNT_LAST)) begin
            fall_s = 1'b1;
        end else begin
            rise_s = 1'b0;
            fall_s = 1'b0;
        end
    end

    // Register the pulses so they line up with the first cycle of the new w.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_rise_r <= 1'b0;
            w_fall_r <= 1'b0;
        end else begin
            w_rise_r <= rise_s;
            w_fall_r <= fall_s;
        end
    end

    assign w_rise = w_rise_r;
    assign w_fall = w_fall_r;
`else
    assign w_rise = 1'b0;
    assign w_fall = 1'b0;
`endif

endmodule

// File: tb/tb_w_input_conditioner.sv
// Testbench for w_input_conditioner: a default instance (2 sync stages,
// 4 debounce cycles) and a swept instance (3 sync stages, 2 debounce cycles)
// driven by directed steps and random bouncy levels, checked against a
// run-length reference model.
module tb_w_input_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic w_raw_a, w_raw_b;
    logic w_a, busy_a, rise_a, fall_a;
    logic w_b, busy_b, rise_b, fall_b;

    int tests = 0;
    int fails = 0;

    // Reference model state, index 0 = default instance, 1 = swept instance.
    logic m_hist [2][4];
    int   m_run  [2];
    logic m_w    [2];
    logic m_rise [2];
    logic m_fall [2];

    always #5 clk = ~clk;

    w_input_conditioner dut_a (
        .clk (clk), .reset (reset), .w_raw (w_raw_a),
        .w (w_a), .busy (busy_a), .w_rise (rise_a), .w_fall (fall_a)
    );

    w_input_conditioner #(
        .SYNC_STAGES (3), .DEBOUNCE_CYCLES (2), .CNT_W (8)
    ) dut_b (
        .clk (clk), .reset (reset), .w_raw (w_raw_b),
        .w (w_b), .busy (busy_b), .w_rise (rise_b), .w_fall (fall_b)
    );

    function automatic int ss_of(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic int dc_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic logic edge_exp(input logic v);
`ifdef W_INPUT_CONDITIONER_EDGE_OUT_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) m_hist[k][j] = 1'b0;
            m_run[k] = 0; m_w[k] = 1'b0; m_rise[k] = 1'b0; m_fall[k] = 1'b0;
        end
    endtask

    // w toggles once DEBOUNCE_CYCLES consecutive synchronized samples disagree.
    task automatic model_step(input int k, input logic raw);
        logic s, prev;
        s = m_hist[k][ss_of(k) - 1];
        for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
        m_hist[k][0] = raw;
        prev = m_w[k];
        if (s !== m_w[k]) m_run[k] = m_run[k] + 1;
        else              m_run[k] = 0;
        if (m_run[k] == dc_of(k)) begin
            m_w[k] = ~m_w[k];
            m_run[k] = 0;
        end
        m_rise[k] = m_w[k] & ~prev;
        m_fall[k] = ~m_w[k] & prev;
    endtask

    task automatic check_all();
        chk("w_a",    w_a,    m_w[0]);
        chk("busy_a", busy_a, (m_run[0] != 0));
        chk("rise_a", rise_a, edge_exp(m_rise[0]));
        chk("fall_a", fall_a, edge_exp(m_fall[0]));
        chk("w_b",    w_b,    m_w[1]);
        chk("busy_b", busy_b, (m_run[1] != 0));
        chk("rise_b", rise_b, edge_exp(m_rise[1]));
        chk("fall_b", fall_b, edge_exp(m_fall[1]));
    endtask

    // One clock: drive inputs on the falling edge, step model, check after rise.
    task automatic cyc(input logic ra, input logic rb, input logic rst_val);
        @(negedge clk);
        w_raw_a = ra;
        w_raw_b = rb;
        reset   = rst_val;
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else begin
            model_step(0, ra);
            model_step(1, rb);
        end
        #1;
        check_all();
    endtask

    // Assert reset mid-cycle, check it acts immediately, then hold n clocks.
    task automatic hold_reset(input int n, input logic ra, input logic rb);
        @(negedge clk);
        w_raw_a = ra;
        w_raw_b = rb;
        #2 reset = 1'b0;
        #1;
        model_clear();
        chk("async_rst_w_a",    w_a,    1'b0);
        chk("async_rst_busy_a", busy_a, 1'b0);
        chk("async_rst_w_b",    w_b,    1'b0);
        chk("async_rst_busy_b", busy_b, 1'b0);
        for (int i = 0; i < n; i++) cyc(ra, rb, 1'b0);
    endtask

    // Release/hold with w_raw high and check the absolute rise latency.
    task automatic rise_latency(input string tag);
        for (int e = 1; e <= 8; e++) begin
            cyc(1'b1, 1'b1, 1'b1);
            chk({tag, "_w_a"},    w_a,    (e >= 6) ? 1'b1 : 1'b0);
            chk({tag, "_busy_a"}, busy_a, (e >= 3 && e <= 5) ? 1'b1 : 1'b0);
            chk({tag, "_rise_a"}, rise_a, edge_exp((e == 6) ? 1'b1 : 1'b0));
            chk({tag, "_w_b"},    w_b,    (e >= 5) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        logic cur_a, cur_b;
        int   left_a, left_b;

        // Reset held with w_raw high: everything stays cleared.
        reset   = 1'b0;
        w_raw_a = 1'b1;
        w_raw_b = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);

        // Release with w_raw already high: w rises after edge 6 (swept: 5).
        rise_latency("rel");

        // Clean fall from w=1.
        for (int e = 1; e <= 8; e++) begin
            cyc(1'b0, 1'b0, 1'b1);
            chk("fall_w_a",    w_a,    (e >= 6) ? 1'b0 : 1'b1);
            chk("fall_pulse_a", fall_a, edge_exp((e == 6) ? 1'b1 : 1'b0));
            chk("fall_w_b",    w_b,    (e >= 5) ? 1'b0 : 1'b1);
        end

        // Clean rise from a settled low level.
        rise_latency("rise");
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1);

        // Bounce on A (3 high, 1 low, 2 high, low); 1-clock glitch on B.
        begin
            logic pa [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            logic pb [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            for (int i = 0; i < 12; i++) begin
                cyc(pa[i], pb[i], 1'b1);
                chk("bounce_w_a", w_a, 1'b0);
                chk("glitch_w_b", w_b, 1'b0);
            end
            chk("bounce_busy_a_idle", busy_a, 1'b0);
            chk("glitch_busy_b_idle", busy_b, 1'b0);
        end

        // Reset in the middle of a rise qualification (A: S_LO_CHK, cnt=2).
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1);
        chk("midq_busy_a", busy_a, 1'b1);
        hold_reset(2, 1'b1, 1'b1);
        rise_latency("midq");

        // Random bouncy levels on both instances.
        cur_a = 1'b1; cur_b = 1'b1; left_a = 0; left_b = 0;
        for (int i = 0; i < 800; i++) begin
            if (left_a == 0) begin
                cur_a = ~cur_a;
                left_a = $urandom_range(1, 7);
            end
            if (left_b == 0) begin
                cur_b = ~cur_b;
                left_b = $urandom_range(1, 4);
            end
            left_a--;
            left_b--;
            cyc(cur_a, cur_b, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
